// File: rtl/xbit_var_delay.sv
// Run-time programmable sample delay (0..MAX_DLY-1 accepted samples) built on a
// circular buffer; a FILL phase swallows the first D samples after reset or a load.
module xbit_var_delay #(
  parameter int DW      = 16,
  parameter int MAX_DLY = 64,
  parameter int DEF_DLY = 0,
  parameter int DLY_W   = $clog2(MAX_DLY)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [DW-1:0]    i_data,
  input  logic             i_cfg_load,
  input  logic [DLY_W-1:0] i_cfg_dly,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_busy,
  output logic             o_cfg_err
);

  localparam int AW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int PW = ((AW > DLY_W) ? AW : DLY_W) + 1;
  localparam logic [DLY_W:0]   CFG_LIM  = (DLY_W+1)'(MAX_DLY - 1);
  localparam logic [DLY_W-1:0] DLY_DEF  = DLY_W'(DEF_DLY);
  localparam logic [AW-1:0]    PTR_LAST = AW'(MAX_DLY - 1);

  typedef enum logic {FILL, RUN} state_t;
  localparam state_t RST_STATE = (DEF_DLY > 0) ? FILL : RUN;

  // Depth need not be a power of two, so the wrap is an explicit add-back.
  function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] ptr,
                                             input logic [DLY_W-1:0] dly);
    logic [PW-1:0] p;
    logic [PW-1:0] d;
    p = PW'(ptr);
    d = PW'(dly);
    if (p >= d) return AW'(p - d);
    return AW'(p + PW'(MAX_DLY) - d);
  endfunction

  logic [DW-1:0]    mem [MAX_DLY];
  state_t           state;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] fill_cnt;
  logic [AW-1:0]    wr_ptr;
  logic             cfg_ok;
  logic             cfg_apply;
  logic [AW-1:0]    rd_addr_p0;
  logic [DW-1:0]    rd_data_p0;
  logic             vld_p1;
  logic [DW-1:0]    data_p1;
  logic             cfg_err_p1;

  // Stage p0: address decode and buffer read alongside the write.
  always_comb begin
    cfg_ok     = ({1'b0, i_cfg_dly} <= CFG_LIM);
    cfg_apply  = i_cfg_load && cfg_ok;
    rd_addr_p0 = wrap_sub(wr_ptr, dly);
  end

  assign rd_data_p0 = mem[rd_addr_p0];

  always_ff @(posedge i_clk) begin
    if (i_valid) mem[wr_ptr] <= i_data;
  end

  // Stage p1: registered output and fill/run control.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= RST_STATE;
      dly        <= DLY_DEF;
      fill_cnt   <= '0;
      wr_ptr     <= '0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      cfg_err_p1 <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      cfg_err_p1 <= i_cfg_load && !cfg_ok;
      if (i_valid) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);

      if (cfg_apply) begin
        dly <= i_cfg_dly;
        if (i_cfg_dly == '0) begin
          state    <= RUN;
          fill_cnt <= '0;
          if (i_valid) begin
            vld_p1  <= 1'b1;
            data_p1 <= i_data;
          end
        end else begin
          // A coincident sample is sample 0 of the new fill.
          state    <= FILL;
          fill_cnt <= i_valid ? DLY_W'(1) : '0;
        end
      end else if (i_valid) begin
        if (state == FILL) begin
          if (fill_cnt == dly) begin
            state   <= RUN;
            vld_p1  <= 1'b1;
            data_p1 <= rd_data_p0;
          end else begin
            fill_cnt <= fill_cnt + DLY_W'(1);
          end
        end else begin
          vld_p1  <= 1'b1;
          data_p1 <= (dly == '0) ? i_data : rd_data_p0;
        end
      end
    end
  end

  assign o_valid   = vld_p1;
  assign o_data    = data_p1;
  assign o_busy    = (state == FILL);
  assign o_cfg_err = cfg_err_p1;

endmodule

// File: tb/tb_xbit_var_delay.sv
// Directed bench for xbit_var_delay with a sample-history reference model and
// an expected-output queue.
module tb_xbit_var_delay;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_cfg_load;
  logic [6:0]  i_cfg_dly;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_busy;
  logic        o_cfg_err;

  xbit_var_delay #(.DW(16), .MAX_DLY(64), .DEF_DLY(0), .DLY_W(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_cfg_load(i_cfg_load), .i_cfg_dly(i_cfg_dly), .o_valid(o_valid),
    .o_data(o_data), .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] hist[$];
  logic [15:0] exp_q[$];
  int          m_dly  = 0;
  int          m_cnt  = 0;
  logic [15:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_dly = 0;
    m_cnt = 0;
    last_data = '0;
  endtask

  // Model: after a valid load (or reset), accepted sample k is output iff k >= D,
  // and its output is the sample D positions earlier in the accepted stream.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic [6:0] c);
    logic        ev;
    logic        eerr;
    logic [15:0] exp_d;
    i_valid = v; i_data = d; i_cfg_load = l; i_cfg_dly = c;
    ev = 1'b0;
    eerr = l && (c > 7'd63);
    if (l && c <= 7'd63) begin
      m_dly = int'(c);
      m_cnt = 0;
    end
    if (v) begin
      hist.push_back(d);
      if (m_cnt >= m_dly) begin
        ev = 1'b1;
        exp_q.push_back(hist[hist.size() - 1 - m_dly]);
      end
      m_cnt++;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_cfg_load = 1'b0;
    chk("valid", 32'(o_valid), 32'(ev));
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(o_data), 32'hFFFF_FFFF);
      end else begin
        exp_d = exp_q.pop_front();
        chk("data", 32'(o_data), 32'(exp_d));
        last_data = exp_d;
      end
    end else begin
      chk("data_hold", 32'(o_data), 32'(last_data));
    end
    chk("busy", 32'(o_busy), 32'((m_dly > 0) && (m_cnt <= m_dly)));
    chk("cfg_err", 32'(o_cfg_err), 32'(eerr));
  endtask

  task automatic put(input logic [15:0] d);
    step(1'b1, d, 1'b0, 7'd0);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 7'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_cfg_load = 1'b0; i_cfg_dly = '0;
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_cfg_err), 32'd0);
    i_rst = 1'b0;
    model_reset();

    // D=0 after reset: 1-clock pass-through.
    put(16'd1); put(16'd2); put(16'd3); idle();

    // D=3 with random bubbles.
    step(1'b0, 16'h0, 1'b1, 7'd3);
    for (int v = 10; v <= 20; v++) begin
      put(16'(v));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // D=63, long stream across pointer wrap.
    step(1'b0, 16'h0, 1'b1, 7'd63);
    for (int i = 0; i < 200; i++) put(16'(16'h100 + i));
    idle();

    // Out-of-range load during RUN at D=2.
    step(1'b0, 16'h0, 1'b1, 7'd2);
    for (int i = 0; i < 5; i++) put(16'(16'h400 + i));
    step(1'b1, 16'h405, 1'b1, 7'd64);
    for (int i = 6; i < 10; i++) put(16'(16'h400 + i));
    step(1'b0, 16'h0, 1'b1, 7'd127);
    idle();

    // Valid load coincident with a sample.
    step(1'b1, 16'h55, 1'b1, 7'd1);
    put(16'h66); put(16'h77); idle();

    // Load D=0 coincident with a sample: immediate bypass.
    step(1'b1, 16'h88, 1'b1, 7'd0);
    put(16'h99); idle();

    // Mid-stream asynchronous reset.
    step(1'b0, 16'h0, 1'b1, 7'd1);
    for (int i = 0; i < 4; i++) put(16'(16'h500 + i));
    i_valid = 1'b1; i_data = 16'h5FF;
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_data", 32'(o_data), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    i_valid = 1'b0;
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1'b0, 16'h0, 1'b1, 7'd2);
    put(16'd7); put(16'd8); put(16'd9); put(16'd10); idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
